// File: rtl/hdmi_cfg_pkg.sv
// Shared types and defaults for the ADV7511 power-up configuration sequencer.
package hdmi_cfg_pkg;

  typedef enum logic [3:0] {
    S_DELAY    = 4'd0,
    S_MUX      = 4'd1,
    S_MUX_WAIT = 4'd2,
    S_ROM      = 4'd3,
    S_WR       = 4'd4,
    S_WR_WAIT  = 4'd5,
    S_BACKOFF  = 4'd6,
    S_DONE     = 4'd7,
    S_ERR      = 4'd8
  } cfg_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam int unsigned CFG_TBL_LEN  = 13;
  localparam logic [6:0]  DEF_MUX_ADDR = 7'h74;
  localparam logic [7:0]  DEF_MUX_CHAN = 8'h20;
  localparam logic [6:0]  DEF_DEV_ADDR = 7'h39;

endpackage

// File: rtl/hdmi_cfg_rom.sv
// ADV7511 register table: synchronous ROM, one cycle from idx to entry.
module hdmi_cfg_rom
  import hdmi_cfg_pkg::*;
(
  input  logic       sys0_clk,
  input  logic [4:0] idx,
  output cfg_entry_t entry
);

  logic [15:0] rd_s;

  // {reg, data} lookup; the last flag is derived from the table length
  always_comb begin
    rd_s = 16'h0000;
    case (idx)
      5'd0:    rd_s = 16'h4110;
      5'd1:    rd_s = 16'h9803;
      5'd2:    rd_s = 16'h9AE0;
      5'd3:    rd_s = 16'h9C30;
      5'd4:    rd_s = 16'h9D61;
      5'd5:    rd_s = 16'hA2A4;
      5'd6:    rd_s = 16'hA3A4;
      5'd7:    rd_s = 16'hE0D0;
      5'd8:    rd_s = 16'hF900;
      5'd9:    rd_s = 16'h1501;  // 16-bit YCbCr 4:2:2 input
      5'd10:   rd_s = 16'h16B5;
      5'd11:   rd_s = 16'h4808;
      5'd12:   rd_s = 16'hAF06;  // HDMI mode
      default: rd_s = 16'h0000;
    endcase
  end

  // registered ROM output
  always_ff @(posedge sys0_clk) begin
    entry.last     <= (idx >= 5'(CFG_TBL_LEN - 1));
    entry.reg_addr <= rd_s[15:8];
    entry.data     <= rd_s[7:0];
  end

endmodule

// File: rtl/hdmi_cfg_seq.sv
// Power-up sequencer: selects the HDMI mux channel, then writes the ADV7511
// register table through a byte-level I2C master, with retry and backoff.
module hdmi_cfg_seq
  import hdmi_cfg_pkg::*;
#(
  parameter logic [6:0]  MUX_ADDR    = DEF_MUX_ADDR,
  parameter logic [7:0]  MUX_CHAN    = DEF_MUX_CHAN,
  parameter logic [6:0]  DEV_ADDR    = DEF_DEV_ADDR,
  parameter logic [19:0] PWR_DLY     = 20'd200000,
  parameter logic [19:0] RSP_TIMEOUT = 20'd100000,
  parameter logic [15:0] BACKOFF     = 16'd20000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       sys0_clk,
  input  logic       sys0_rst,
  input  logic       cfg_start,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [6:0] req_dev,
  output logic       req_two,
  output logic [7:0] req_b0,
  output logic [7:0] req_b1,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [4:0] cfg_idx
);

  cfg_state_e  state_r, state_s;
  cfg_state_e  ret_st_r, ret_st_s;
  logic [19:0] cnt_r, cnt_s;
  logic [2:0]  retry_r, retry_s;
  logic [4:0]  idx_r, idx_s;
  logic        timeout_s, bo_end_s;
  cfg_entry_t  rom_q_s;

  // ROM is addressed with the next index so its output is valid during S_ROM
  hdmi_cfg_rom u_rom (
    .sys0_clk (sys0_clk),
    .idx      (idx_s),
    .entry    (rom_q_s)
  );

  assign timeout_s = (cnt_r >= RSP_TIMEOUT - 20'd1);
  assign bo_end_s  = (cnt_r >= {4'd0, BACKOFF} - 20'd1);

  // next-state, index, retry and shared-counter logic
  always_comb begin
    state_s  = state_r;
    ret_st_s = ret_st_r;
    idx_s    = idx_r;
    retry_s  = retry_r;
    cnt_s    = cnt_r;
    case (state_r)
      S_DELAY: begin
        if (cnt_r >= PWR_DLY - 20'd1) state_s = S_MUX;
        else                          state_s = S_DELAY;
      end
      S_MUX: begin
        if (req_ready) state_s = S_MUX_WAIT;
        else           state_s = S_MUX;
      end
      S_MUX_WAIT: begin
        if (rsp_valid && !rsp_nack) begin
          state_s = S_ROM;
          idx_s   = 5'd0;
          retry_s = 3'd0;
        end else if (rsp_valid || timeout_s) begin
          state_s  = S_BACKOFF;
          ret_st_s = S_MUX;
        end else begin
          state_s = S_MUX_WAIT;
        end
      end
      S_ROM: state_s = S_WR;
      S_WR: begin
        if (req_ready) state_s = S_WR_WAIT;
        else           state_s = S_WR;
      end
      S_WR_WAIT: begin
        if (rsp_valid && !rsp_nack) begin
          retry_s = 3'd0;
          if (rom_q_s.last) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ROM;
            idx_s   = idx_r + 5'd1;
          end
        end else if (rsp_valid || timeout_s) begin
          state_s  = S_BACKOFF;
          ret_st_s = S_WR;
        end else begin
          state_s = S_WR_WAIT;
        end
      end
      S_BACKOFF: begin
        if (retry_r == 3'(MAX_RETRY)) begin
          state_s = S_ERR;
        end else if (bo_end_s) begin
          state_s = ret_st_r;
          retry_s = retry_r + 3'd1;
        end else begin
          state_s = S_BACKOFF;
        end
      end
      S_DONE, S_ERR: begin
        if (cfg_start) begin
          state_s = S_DELAY;
          idx_s   = 5'd0;
          retry_s = 3'd0;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = S_DELAY;
    endcase
    // one counter serves delay, timeout and backoff; restarts on every state change
    if (state_s != state_r)       cnt_s = 20'd0;
    else if (cnt_r != 20'hFFFFF)  cnt_s = cnt_r + 20'd1;
    else                          cnt_s = cnt_r;
  end

  // state, counters and registered outputs
  always_ff @(posedge sys0_clk) begin
    if (sys0_rst) begin
      state_r   <= S_DELAY;
      ret_st_r  <= S_MUX;
      cnt_r     <= 20'd0;
      retry_r   <= 3'd0;
      idx_r     <= 5'd0;
      req_valid <= 1'b0;
      req_dev   <= 7'd0;
      req_two   <= 1'b0;
      req_b0    <= 8'd0;
      req_b1    <= 8'd0;
      cfg_busy  <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_idx   <= 5'd0;
    end else begin
      state_r   <= state_s;
      ret_st_r  <= ret_st_s;
      cnt_r     <= cnt_s;
      retry_r   <= retry_s;
      idx_r     <= idx_s;
      req_valid <= (state_s == S_MUX) || (state_s == S_WR);
      if (state_s == S_MUX) begin
        req_dev <= MUX_ADDR;
        req_two <= 1'b0;
        req_b0  <= MUX_CHAN;
        req_b1  <= 8'd0;
      end else if (state_s == S_WR) begin
        req_dev <= DEV_ADDR;
        req_two <= 1'b1;
        req_b0  <= rom_q_s.reg_addr;
        req_b1  <= rom_q_s.data;
      end
      cfg_busy  <= !((state_s == S_DONE) || (state_s == S_ERR));
      cfg_done  <= (state_s == S_DONE);
      cfg_err   <= (state_s == S_ERR);
      cfg_idx   <= idx_s;
    end
  end

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Directed bench for hdmi_cfg_seq: a scripted I2C responder logs every accepted
// request and the log is compared against hand-written expected sequences.
module tb_hdmi_cfg_seq;

  localparam int BO  = 8;
  localparam int TMO = 100;

  logic       sys0_clk = 1'b0;
  logic       sys0_rst, cfg_start, req_ready, rsp_valid, rsp_nack;
  logic       req_valid, req_two, cfg_busy, cfg_done, cfg_err;
  logic [6:0] req_dev;
  logic [7:0] req_b0, req_b1;
  logic [4:0] cfg_idx;

  hdmi_cfg_seq #(
    .PWR_DLY     (20'd10),
    .RSP_TIMEOUT (20'd100),
    .BACKOFF     (16'd8),
    .MAX_RETRY   (3)
  ) dut (
    .sys0_clk  (sys0_clk),
    .sys0_rst  (sys0_rst),
    .cfg_start (cfg_start),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dev   (req_dev),
    .req_two   (req_two),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .cfg_idx   (cfg_idx)
  );

  always #5 sys0_clk = ~sys0_clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [23:0] xf;   // {dev, two, b0, b1}
  } log_t;

  log_t        log_q[$];
  logic [23:0] exp_q[$];
  logic [15:0] tbl [13];
  int          total = 0;
  int          bad = 0;
  int          cyc, first_valid, n;
  logic [7:0]  nack_reg, stall_reg;
  int          nack_left, stall_left, stall_seen, silent_left, silent_cyc;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_policy();
    nack_reg    = 8'hFF;
    nack_left   = 0;
    stall_reg   = 8'hFF;
    stall_left  = 0;
    stall_seen  = 0;
    silent_left = 0;
    silent_cyc  = -1;
  endtask

  // responder: answers each accepted request on the next cycle unless scripted otherwise
  task automatic set_inputs(input logic acc, input logic [23:0] xf);
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    if (acc) begin
      if (xf[23:17] == 7'h74 && silent_left > 0) begin
        silent_left--;
        silent_cyc = cyc;
      end else begin
        rsp_valid = 1'b1;
        if (xf[16] && xf[15:8] == nack_reg && nack_left > 0) begin
          rsp_nack = 1'b1;
          nack_left--;
        end
      end
    end
    if (silent_cyc >= 0 && (cyc == silent_cyc + 103 || cyc == silent_cyc + 106))
      rsp_valid = 1'b1;
    req_ready = 1'b1;
    if (req_valid && req_two && req_b0 == stall_reg && stall_left > 0) begin
      req_ready = 1'b0;
      stall_left--;
      stall_seen++;
      chk("stall_hold", {req_valid, req_dev, req_two, req_b0, req_b1},
          {1'b1, 7'h39, 1'b1, 8'h9C, 8'h30});
    end
  endtask

  task automatic tick();
    logic        acc;
    logic [23:0] xf;
    acc = req_valid && req_ready;
    xf  = {req_dev, req_two, req_b0, req_b1};
    if (req_valid && first_valid < 0) first_valid = cyc;
    @(posedge sys0_clk);
    #1;
    cyc++;
    if (acc) log_q.push_back({32'(cyc), xf});
    set_inputs(acc, xf);
  endtask

  task automatic do_reset();
    sys0_rst  = 1'b1;
    cfg_start = 1'b0;
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    repeat (3) @(posedge sys0_clk);
    #1;
    sys0_rst    = 1'b0;
    cyc         = 0;
    first_valid = -1;
    log_q.delete();
  endtask

  task automatic start_pulse();
    log_q.delete();
    cfg_start = 1'b1;
    tick();
    cfg_start   = 1'b0;
    cyc         = 0;
    first_valid = -1;
  endtask

  task automatic wait_end(input string tag);
    int k;
    k = 0;
    while (!(cfg_done || cfg_err) && k < 3000) begin
      tick();
      k++;
    end
    chk({tag, "_end"}, 40'(k < 3000), 40'd1);
  endtask

  task automatic exp_mux();
    exp_q.push_back({7'h74, 1'b0, 8'h20, 8'h00});
  endtask

  task automatic exp_ent(input int i);
    exp_q.push_back({7'h39, 1'b1, tbl[i]});
  endtask

  task automatic check_log(input string tag);
    logic [23:0] got;
    chk({tag, "_len"}, 40'(log_q.size()), 40'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      got = log_q[i].xf;
      if (!got[16]) got[7:0] = 8'h00;   // b1 is don't-care on one-byte writes
      chk($sformatf("%s[%0d]", tag, i), 40'(got), 40'(exp_q[i]));
    end
  endtask

  task automatic chk_rst_state(input string tag);
    chk(tag, {req_valid, req_two, cfg_busy, cfg_done, cfg_err, cfg_idx, req_dev, req_b0, req_b1},
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 7'd0, 8'd0, 8'd0});
  endtask

  initial begin
    tbl = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4, 16'hA3A4,
            16'hE0D0, 16'hF900, 16'h1501, 16'h16B5, 16'h4808, 16'hAF06};

    // plain run from reset
    clear_policy();
    do_reset();
    chk_rst_state("rst_state");
    set_inputs(1'b0, 24'd0);
    wait_end("run1");
    chk("run1_first_valid", 40'(first_valid), 40'd10);
    exp_q.delete(); exp_mux();
    for (int i = 0; i < 13; i++) exp_ent(i);
    check_log("run1");
    chk("run1_status", {cfg_done, cfg_busy, cfg_err, cfg_idx}, {1'b1, 1'b0, 1'b0, 5'd12});

    // restart with req_ready held low for 50 cycles on entry 3
    clear_policy();
    stall_reg  = 8'h9C;
    stall_left = 50;
    start_pulse();
    chk("start_clear", {cfg_done, cfg_busy}, {1'b0, 1'b1});
    wait_end("stall");
    chk("stall_cycles", 40'(stall_seen), 40'd50);
    check_log("stall");
    chk("stall_done", {cfg_done, cfg_err}, {1'b1, 1'b0});

    // entry 5 NACKed twice, then acked
    clear_policy();
    nack_reg  = 8'hA2;
    nack_left = 2;
    start_pulse();
    wait_end("nack2");
    exp_q.delete(); exp_mux();
    for (int i = 0; i < 13; i++) begin
      exp_ent(i);
      if (i == 5) begin exp_ent(5); exp_ent(5); end
    end
    check_log("nack2");
    // accept-to-accept: one response cycle, BO backoff cycles, one request cycle
    if (log_q.size() >= 9) begin
      chk("nack2_gap1", 40'(log_q[7].cyc - log_q[6].cyc), 40'(BO + 2));
      chk("nack2_gap2", 40'(log_q[8].cyc - log_q[7].cyc), 40'(BO + 2));
    end else begin
      chk("nack2_gap_log", 40'(log_q.size()), 40'd16);
    end
    chk("nack2_done", {cfg_done, cfg_err}, {1'b1, 1'b0});

    // entry 2 NACKed on every attempt
    clear_policy();
    nack_reg  = 8'h9A;
    nack_left = 100;
    start_pulse();
    wait_end("err");
    exp_q.delete(); exp_mux();
    exp_ent(0); exp_ent(1);
    for (int i = 0; i < 4; i++) exp_ent(2);
    check_log("err");
    chk("err_status", {cfg_done, cfg_busy, cfg_err, cfg_idx}, {1'b0, 1'b0, 1'b1, 5'd2});
    repeat (200) tick();
    chk("err_quiet", 40'(log_q.size()), 40'd7);
    chk("err_hold", {req_valid, cfg_err, cfg_idx}, {1'b0, 1'b1, 5'd2});

    // silent mux responder with late pulses during backoff
    clear_policy();
    silent_left = 1;
    do_reset();
    set_inputs(1'b0, 24'd0);
    wait_end("silent");
    exp_q.delete(); exp_mux(); exp_mux();
    for (int i = 0; i < 13; i++) exp_ent(i);
    check_log("silent");
    if (log_q.size() >= 2)
      chk("silent_gap", 40'(log_q[1].cyc - log_q[0].cyc), 40'(TMO + BO + 1));
    else
      chk("silent_gap_log", 40'(log_q.size()), 40'd15);
    chk("silent_done", {cfg_done, cfg_err}, {1'b1, 1'b0});

    // reset asserted right after entry 7 is accepted
    clear_policy();
    start_pulse();
    n = 0;
    while (!(log_q.size() > 0 && log_q[log_q.size()-1].xf[15:8] == 8'hE0) && n < 500) begin
      tick();
      n++;
    end
    chk("mid_reach", 40'(n < 500), 40'd1);
    sys0_rst = 1'b1;
    tick();
    chk_rst_state("mid_rst_state");
    sys0_rst    = 1'b0;
    cyc         = 0;
    first_valid = -1;
    log_q.delete();
    wait_end("rerun");
    chk("rerun_first_valid", 40'(first_valid), 40'd10);
    exp_q.delete(); exp_mux();
    for (int i = 0; i < 13; i++) exp_ent(i);
    check_log("rerun");
    chk("rerun_done", {cfg_done, cfg_busy, cfg_err}, {1'b1, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_cfg_seq.md
Name: hdmi_cfg_seq

Overview:
Power-up configuration sequencer for the ADV7511 HDMI transmitter on the KC705. It first selects the HDMI channel on the board I2C mux (PCA9548). It then walks a fixed register table and issues one I2C write per entry through a byte-level I2C master request/response interface. NACKs and timeouts are retried with backoff, and done/error status is reported to LEDs and control logic. It sits beside the video timing/pattern logic on the sys0_clk domain and drives the existing I2C master.

Parameters:
MUX_ADDR, 7'h74, 7-bit I2C address of the PCA9548 mux
MUX_CHAN, 8'h20, mux control byte that enables the HDMI channel (bit 5)
DEV_ADDR, 7'h39, 7-bit I2C address of the ADV7511
PWR_DLY, 20'd200000, cycles to wait after reset before the first transaction (1 ms at 200 MHz)
RSP_TIMEOUT, 20'd100000, cycles to wait for rsp_valid before treating the transaction as a NACK
BACKOFF, 16'd20000, cycles to wait between a failure and its retry
MAX_RETRY, 3, retries per entry before giving up (attempts = MAX_RETRY+1)

Ports:
sys0_clk  in  1  clock, 200 MHz
sys0_rst  in  1  synchronous reset, active-high
cfg_start  in  1  one-cycle pulse; restarts the whole sequence from S_DELAY when in S_DONE or S_ERR
req_valid  out  1  I2C write request valid
req_ready  in  1  I2C master accepts the request
req_dev  out  7  7-bit device address
req_two  out  1  0: one data byte (req_b0 only); 1: two bytes (req_b0 then req_b1)
req_b0  out  8  first byte (register address, or mux control byte)
req_b1  out  8  second byte (register data)
rsp_valid  in  1  one-cycle completion pulse from the I2C master
rsp_nack  in  1  valid with rsp_valid; 1 means any byte was NACKed
cfg_busy  out  1  sequence in progress
cfg_done  out  1  all entries written successfully; sticky until reset or cfg_start
cfg_err  out  1  an entry exhausted its retries; sticky until reset or cfg_start
cfg_idx  out  5  current table index (mux phase reports 0)

Behaviour:
- Reset values: state=S_DELAY, req_valid=0, req_dev/req_b0/req_b1=0, req_two=0, cfg_busy=1, cfg_done=0, cfg_err=0, cfg_idx=0, all counters 0.
- Reset asserted mid-transaction: the sequencer returns to S_DELAY in the next cycle. Any late rsp_valid after reset is ignored because it is only sampled in wait states.
- Handshake:
  - req_valid is held high with stable req_* until the cycle where req_valid&&req_ready.
  - Exactly one request is outstanding.
  - rsp_valid is sampled only in S_MUX_WAIT and S_WR_WAIT, and ignored elsewhere.
- S_DELAY: count to PWR_DLY-1, then go to S_MUX.
- S_MUX: present {MUX_ADDR, two=0, b0=MUX_CHAN}. On accept, go to S_MUX_WAIT.
- S_MUX_WAIT:
  - rsp_valid && !rsp_nack: go to S_ROM with idx=0.
  - NACK, or timeout counter reaching RSP_TIMEOUT: go to S_BACKOFF with ret_st=S_MUX.
- S_ROM: one cycle to register the ROM output {last, reg, data} for idx, then go to S_WR.
- S_WR: present {DEV_ADDR, two=1, b0=reg, b1=data}. On accept, go to S_WR_WAIT.
- S_WR_WAIT:
  - ack && last: go to S_DONE.
  - ack && !last: idx+1, retry count=0, go to S_ROM.
  - NACK or timeout: go to S_BACKOFF with ret_st=S_WR (the ROM output is still held).
- S_BACKOFF:
  - If retry count==MAX_RETRY, go to S_ERR.
  - Otherwise wait BACKOFF cycles, increment retry count, and return to ret_st.
  - The retry count covers the mux phase and each table entry separately; it is cleared on every ack.
- S_DONE: cfg_done=1, cfg_busy=0. S_ERR: cfg_err=1, cfg_busy=0, and cfg_idx freezes at the failing entry.
- cfg_start in S_DONE or S_ERR: clear done/err/idx/retry, go to S_DELAY. cfg_start in any other state is ignored.
- Timeout counter: cleared on entry to each wait state. It saturates and does not wrap.
- Width rule: idx is 5 bits and the table has at most 32 entries. The last flag terminates the walk; idx never wraps.
- ROM table, 13 entries, {reg,data}:
  - 41/10, 98/03, 9A/E0, 9C/30, 9D/61, A2/A4, A3/A4, E0/D0, F9/00
  - 15/01 (16-bit YCbCr 4:2:2 input), 16/B5, 48/08, AF/06 (HDMI mode, last=1)

Decomposition:
- Package hdmi_cfg_pkg holds: the state enum, the ROM entry struct {last, reg[7:0], data[7:0]}, the table length constant, and default addresses.
- Sub-module hdmi_cfg_rom: a synchronous 1-cycle-latency case ROM, idx -> entry. Table edits stay isolated there.

Test Plan:
- Reset, always-ready/always-ack model, PWR_DLY=10:
  - First req_valid at cycle 10 with dev=74, two=0, b0=20.
  - Then 13 writes in table order, dev=39.
  - The final write is AF/06; cfg_done=1 and cfg_busy=0 after its ack.
- req_ready held low 50 cycles during entry 3: req_* are stable for all 50 cycles, and exactly one write of 9C/30 occurs.
- NACK entry 5 twice, then ack (BACKOFF=8): three A2/A4 requests with 8 idle cycles between them, then entry 6 proceeds and cfg_done=1.
- NACK entry 2 on every attempt (MAX_RETRY=3): 4 attempts of 9A/E0, then cfg_err=1, cfg_idx=2, cfg_done=0, and no further requests.
- Responder silent on the mux write, with RSP_TIMEOUT=100 and BACKOFF=8: mux request reissued after 108 cycles; late rsp_valid pulses arriving in S_BACKOFF are ignored.
- After cfg_done, a cfg_start pulse clears done and re-runs the full sequence. sys0_rst asserted mid-sequence at entry 7 returns the block to S_DELAY with all outputs at reset values the next cycle.
